t_latch: RTL and testbench
==========================

Name: t_latch

Overview:
- Clocked toggle-storage element: a T latch behaviour built as a synchronous design.
- While enable `e` is high, each rising clock edge with `t` high inverts the stored state `q`.
- `q_bar` is always the complement of `q`.
- Vectorised by `WIDTH`, so one instance can hold a bank of independent toggle bits used as state/flag toggles in control logic.

Parameters:
- WIDTH, 1, number of independent toggle bits; all per-bit ports are WIDTH wide.
- RESET_VAL, {WIDTH{1'b0}}, value loaded into `q` on reset; `q_bar` resets to ~RESET_VAL.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- e  input  WIDTH  per-bit enable; bit i may change only when e[i]=1.
- t  input  WIDTH  per-bit toggle request; acts only when the matching e bit is 1.
- q  output  WIDTH  stored state, registered.
- q_bar  output  WIDTH  bitwise complement of q, registered, never equal to q in any bit.
- toggled  output  WIDTH  registered one-cycle flag; bit i=1 when q[i] inverted at the last rising edge.

Behaviour:
- All outputs change only on the rising clk edge; no combinational path from inputs to outputs.
- Reset: if rst=1 at a rising edge, then q<=RESET_VAL, q_bar<=~RESET_VAL and toggled<=0, regardless of e and t. Reset takes priority over toggle.
- After reset deasserts, the first clk edge evaluates e and t normally. No extra dead cycle.
- Per bit i, with rst=0, at each rising edge:
  - e[i]=0, any t[i]: q[i] holds; toggled[i]<=0.
  - e[i]=1, t[i]=0: q[i] holds; toggled[i]<=0.
  - e[i]=1, t[i]=1: q[i]<=~q[i]; toggled[i]<=1.
- Latency: one clock from the sampled request (e=1, t=1) to the new q and q_bar and to toggled=1.
- Continuous e=t=1: q inverts on every edge, giving a divide-by-2 of clk; toggled stays 1.
- q_bar is a separate register updated in lockstep with q. The invariant q_bar==~q holds in every cycle, including the reset cycle.
- Bits are fully independent: simultaneous requests on several bits all take effect in the same edge.
- Before the first reset, outputs are undefined (X in simulation). Benches must reset first.
- Reset mid-toggle: a toggle request sampled in the same cycle as rst=1 is discarded.

Decomposition:
- Shared package t_latch_pkg holds:
  - the default WIDTH constant (1);
  - the default reset-value constant (all-zeros);
  - an enum or constants naming the e/t operation codes: HOLD_DIS=2'b00/01, HOLD=2'b10, TOGGLE=2'b11 for {e,t}.
- One natural sub-module: t_latch_bit, a single-bit cell (q, q_bar, toggled with reset value). The top generates WIDTH copies of it.

Test Plan:
- Reset: rst=1 for 2 edges with e=1, t=1 -> q=0, q_bar=1, toggled=0 after each edge (WIDTH=1, RESET_VAL=0).
- Truth sweep: after reset, apply {e,t}=00, 01, 10, 11, each held 1 clock. Required values after each edge:
  - 00 -> q=0, q_bar=1, toggled=0
  - 01 -> q=0, q_bar=1, toggled=0
  - 10 -> q=0, q_bar=1, toggled=0
  - 11 -> q=1, q_bar=0, toggled=1
- Continuous toggle: e=1, t=1 for 4 edges from q=0 -> q sequence 1,0,1,0; toggled=1 each cycle; q_bar always ~q.
- Hold under disable: q=1, then e=0, t=1 for 3 edges -> q stays 1, toggled=0.
- Reset priority: q=1, rst=1 with e=1, t=1 at the same edge -> q=0, q_bar=1, toggled=0. Next edge with rst=0, e=t=1 -> q=1.
- Vector independence (WIDTH=4, RESET_VAL=4'b1010): after reset, e=4'b1111, t=4'b0101 for 1 edge -> q=4'b1111, q_bar=4'b0000, toggled=4'b0101.

Source files
------------

// File: rtl/t_latch_pkg.sv
// Shared constants and the {e,t} operation encoding for the t_latch toggle bank.
package t_latch_pkg;

   localparam int unsigned DEFAULT_WIDTH     = 1;
   localparam logic        DEFAULT_RESET_BIT = 1'b0;

   // Operation selected by the {e,t} pair of a single bit.
   typedef enum logic [1:0] {
      HOLD_DIS   = 2'b00,
      HOLD_DIS_T = 2'b01,
      HOLD       = 2'b10,
      TOGGLE     = 2'b11
   } op_e;

   function automatic op_e decode_op(input logic e, input logic t);
      return op_e'({e, t});
   endfunction

endpackage

// File: rtl/t_latch_if.sv
// Bundle of per-bit request inputs and registered state outputs of a toggle bank.
interface t_latch_if
   import t_latch_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] e;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] q_bar;
   logic [WIDTH-1:0] toggled;

   modport master (output e, output t, input q, input q_bar, input toggled);
   modport slave  (input e, input t, output q, output q_bar, output toggled);

endinterface

// File: rtl/t_latch_bit.sv
// Single toggle cell: q and q_bar held in separate registers that move in lockstep.
module t_latch_bit
   import t_latch_pkg::*;
#(
   parameter logic RESET_VAL = DEFAULT_RESET_BIT
) (
   input  logic clk,
   input  logic rst,
   input  logic e,
   input  logic t,
   output logic q,
   output logic q_bar,
   output logic toggled
);

   logic q_q, q_d;
   logic q_bar_q, q_bar_d;
   logic toggled_q, toggled_d;
   op_e  op;

   always_comb begin
      op        = decode_op(e, t);
      q_d       = q_q;
      q_bar_d   = q_bar_q;
      toggled_d = 1'b0;
      case (op)
         TOGGLE: begin
            q_d       = ~q_q;
            q_bar_d   = ~q_bar_q;
            toggled_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_q       <= RESET_VAL;
         q_bar_q   <= ~RESET_VAL;
         toggled_q <= 1'b0;
      end else begin
         q_q       <= q_d;
         q_bar_q   <= q_bar_d;
         toggled_q <= toggled_d;
      end
   end

   assign q       = q_q;
   assign q_bar   = q_bar_q;
   assign toggled = toggled_q;

endmodule

// File: rtl/t_latch.sv
// Bank of WIDTH independent clocked toggle bits with registered complement and toggle flag.
module t_latch
   import t_latch_pkg::*;
#(
   parameter int unsigned         WIDTH     = DEFAULT_WIDTH,
   parameter logic [WIDTH-1:0]    RESET_VAL = {WIDTH{DEFAULT_RESET_BIT}}
) (
   input  logic     clk,
   input  logic     rst,
   t_latch_if.slave bus
);

   logic [WIDTH-1:0] q_w;
   logic [WIDTH-1:0] q_bar_w;
   logic [WIDTH-1:0] toggled_w;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_latch_bit #(
         .RESET_VAL (RESET_VAL[i])
      ) u_bit (
         .clk     (clk),
         .rst     (rst),
         .e       (bus.e[i]),
         .t       (bus.t[i]),
         .q       (q_w[i]),
         .q_bar   (q_bar_w[i]),
         .toggled (toggled_w[i])
      );
   end

   assign bus.q       = q_w;
   assign bus.q_bar   = q_bar_w;
   assign bus.toggled = toggled_w;

endmodule

// File: tb/tb_t_latch.sv
// Directed bench: a 1-bit bank for the scalar sequence and a 4-bit bank for vector behaviour.
module tb_t_latch;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   t_latch_if #(.WIDTH(1)) if1 ();
   t_latch_if #(.WIDTH(4)) if4 ();

   t_latch #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   t_latch #(.WIDTH(4), .RESET_VAL(4'b1010)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
      end
   endtask

   task automatic chk1(input string tag, input logic eq, input logic eqb, input logic etog);
      chk({tag, ".q"},       {3'b000, if1.q},       {3'b000, eq});
      chk({tag, ".q_bar"},   {3'b000, if1.q_bar},   {3'b000, eqb});
      chk({tag, ".toggled"}, {3'b000, if1.toggled}, {3'b000, etog});
   endtask

   task automatic chk4(input string tag, input logic [3:0] eq, input logic [3:0] eqb,
                       input logic [3:0] etog);
      chk({tag, ".q"},       if4.q,       eq);
      chk({tag, ".q_bar"},   if4.q_bar,   eqb);
      chk({tag, ".toggled"}, if4.toggled, etog);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;

      // Reset held two edges with toggle requests active on both banks.
      rst = 1'b1; if1.e = 1'b1; if1.t = 1'b1; if4.e = 4'b1111; if4.t = 4'b1111;
      step(); chk1("rst0", 1'b0, 1'b1, 1'b0); chk4("rst0_v", 4'b1010, 4'b0101, 4'b0000);
      step(); chk1("rst1", 1'b0, 1'b1, 1'b0); chk4("rst1_v", 4'b1010, 4'b0101, 4'b0000);

      // Truth sweep on the scalar bank; vector independence on the first edge.
      rst = 1'b0;
      if4.e = 4'b1111; if4.t = 4'b0101;
      if1.e = 1'b0; if1.t = 1'b0; step(); chk1("et00", 1'b0, 1'b1, 1'b0);
      chk4("vec", 4'b1111, 4'b0000, 4'b0101);
      if4.e = 4'b0000; if4.t = 4'b1111;
      if1.e = 1'b0; if1.t = 1'b1; step(); chk1("et01", 1'b0, 1'b1, 1'b0);
      chk4("vec_hold", 4'b1111, 4'b0000, 4'b0000);
      if4.e = 4'b0011; if4.t = 4'b0110;
      if1.e = 1'b1; if1.t = 1'b0; step(); chk1("et10", 1'b0, 1'b1, 1'b0);
      chk4("vec_mix", 4'b1101, 4'b0010, 4'b0010);
      if4.e = 4'b0000; if4.t = 4'b0000;
      if1.e = 1'b1; if1.t = 1'b1; step(); chk1("et11", 1'b1, 1'b0, 1'b1);

      // Back to q=0, then continuous toggling.
      step(); chk1("pre_cont", 1'b0, 1'b1, 1'b1);
      step(); chk1("cont0", 1'b1, 1'b0, 1'b1);
      step(); chk1("cont1", 1'b0, 1'b1, 1'b1);
      step(); chk1("cont2", 1'b1, 1'b0, 1'b1);
      step(); chk1("cont3", 1'b0, 1'b1, 1'b1);

      // Set q=1, then hold with enable low and toggle high.
      step(); chk1("set1", 1'b1, 1'b0, 1'b1);
      if1.e = 1'b0; if1.t = 1'b1;
      step(); chk1("dis0", 1'b1, 1'b0, 1'b0);
      step(); chk1("dis1", 1'b1, 1'b0, 1'b0);
      step(); chk1("dis2", 1'b1, 1'b0, 1'b0);

      // Reset wins over a simultaneous toggle; next edge toggles normally.
      rst = 1'b1; if1.e = 1'b1; if1.t = 1'b1;
      step(); chk1("rst_prio", 1'b0, 1'b1, 1'b0);
      chk4("rst_prio_v", 4'b1010, 4'b0101, 4'b0000);
      rst = 1'b0;
      step(); chk1("post_rst", 1'b1, 1'b0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
